tft_spi_receiver: RTL and testbench



---
 rtl/tft_pkg.sv | 22 ++
 rtl/tft_spi_receiver_if.sv | 31 +++
 rtl/spi_byte_rx.sv | 106 ++++++++++
 rtl/tft_spi_receiver.sv | 158 +++++++++++++++
 tb/tb_tft_spi_receiver.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tft_pkg.sv
// rtl/tft_pkg.sv - shared command codes, widths and decoder state type for the TFT SPI receiver
package tft_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam int RGB565_W = 16;
    localparam int PANEL_W  = 240;
    localparam int PANEL_H  = 320;
    localparam int ADDR_W   = 16;
    localparam int COORD_W  = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET_P,
        ST_PASET_P,
        ST_RAMWR_HI,
        ST_RAMWR_LO
    } dec_state_t;

endpackage

// File: rtl/tft_spi_receiver_if.sv
// rtl/tft_spi_receiver_if.sv - SPI pins and decoded byte/pixel outputs of the TFT SPI receiver
interface tft_spi_receiver_if;
    import tft_pkg::*;

    logic                spi_sclk;
    logic                spi_mosi;
    logic                spi_dc;
    logic                spi_cs;

    logic [7:0]          byte_data;
    logic                byte_dc;
    logic                byte_valid;
    logic                ramwr_active;
    logic                pixel_valid;
    logic [COORD_W-1:0]  pixel_x;
    logic [COORD_W-1:0]  pixel_y;
    logic [RGB565_W-1:0] pixel_color;

    modport master (
        output spi_sclk, spi_mosi, spi_dc, spi_cs,
        input  byte_data, byte_dc, byte_valid, ramwr_active,
        input  pixel_valid, pixel_x, pixel_y, pixel_color
    );

    modport slave (
        input  spi_sclk, spi_mosi, spi_dc, spi_cs,
        output byte_data, byte_dc, byte_valid, ramwr_active,
        output pixel_valid, pixel_x, pixel_y, pixel_color
    );

endinterface

// File: rtl/spi_byte_rx.sv
// rtl/spi_byte_rx.sv - SPI mode-0 byte deserializer; TFT_RX_SYNC_EN adds 2-flop input synchronizers
module spi_byte_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    input  logic       spi_dc,
    input  logic       spi_cs,
    output logic [7:0] byte_data,
    output logic       byte_dc,
    output logic       byte_valid
);

    logic sclk_in;
    logic mosi_in;
    logic dc_in;
    logic cs_in;

`ifdef TFT_RX_SYNC_EN
    logic [1:0] sclk_sync;
    logic [1:0] mosi_sync;
    logic [1:0] dc_sync;
    logic [1:0] cs_sync;

    // Two-flop synchronizers; all four pins share the same delay so data stays aligned with sclk.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            dc_sync   <= 2'b00;
            cs_sync   <= 2'b11;
        end else begin
            sclk_sync <= {sclk_sync[0], spi_sclk};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            dc_sync   <= {dc_sync[0], spi_dc};
            cs_sync   <= {cs_sync[0], spi_cs};
        end
    end

    assign sclk_in = sclk_sync[1];
    assign mosi_in = mosi_sync[1];
    assign dc_in   = dc_sync[1];
    assign cs_in   = cs_sync[1];
`else
    assign sclk_in = spi_sclk;
    assign mosi_in = spi_mosi;
    assign dc_in   = spi_dc;
    assign cs_in   = spi_cs;
`endif

    logic sclk_d;
    logic sclk_dd;
    logic mosi_d;
    logic dc_d;
    logic cs_d;
    logic sclk_rise;

    // Edge-detect stage; mosi/dc/cs are registered alongside so they line up with the detected rise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_d  <= 1'b0;
            sclk_dd <= 1'b0;
            mosi_d  <= 1'b0;
            dc_d    <= 1'b0;
            cs_d    <= 1'b1;
        end else begin
            sclk_d  <= sclk_in;
            sclk_dd <= sclk_d;
            mosi_d  <= mosi_in;
            dc_d    <= dc_in;
            cs_d    <= cs_in;
        end
    end

    assign sclk_rise = sclk_d & ~sclk_dd;

    logic [2:0] bit_cnt;
    logic [6:0] shift_reg;

    // Shift in bits MSB first; the 8th rise publishes the byte with the dc seen on bit 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt    <= 3'd0;
            shift_reg  <= 7'd0;
            byte_data  <= 8'd0;
            byte_dc    <= 1'b0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (cs_d) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                shift_reg <= {shift_reg[5:0], mosi_d};
                if (bit_cnt == 3'd7) begin
                    bit_cnt    <= 3'd0;
                    byte_data  <= {shift_reg, mosi_d};
                    byte_dc    <= dc_d;
                    byte_valid <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/tft_spi_receiver.sv
// rtl/tft_spi_receiver.sv - TFT SPI panel model: CASET/PASET/RAMWR decode into RGB565 pixel writes; option TFT_RX_SYNC_EN
module tft_spi_receiver
    import tft_pkg::*;
#(
    parameter logic [ADDR_W-1:0] X_END_DEFAULT = 16'd239,
    parameter logic [ADDR_W-1:0] Y_END_DEFAULT = 16'd319
) (
    input logic               clk,
    input logic               rst,
    tft_spi_receiver_if.slave bus
);

    logic [7:0] rx_data;
    logic       rx_dc;
    logic       rx_valid;

    spi_byte_rx u_byte_rx (
        .clk        (clk),
        .rst        (rst),
        .spi_sclk   (bus.spi_sclk),
        .spi_mosi   (bus.spi_mosi),
        .spi_dc     (bus.spi_dc),
        .spi_cs     (bus.spi_cs),
        .byte_data  (rx_data),
        .byte_dc    (rx_dc),
        .byte_valid (rx_valid)
    );

    dec_state_t          state, state_n;
    logic [1:0]          param_idx, param_idx_n;
    logic [ADDR_W-1:0]   x_start, x_start_n, x_end, x_end_n;
    logic [ADDR_W-1:0]   y_start, y_start_n, y_end, y_end_n;
    logic [ADDR_W-1:0]   cur_x, cur_x_n, cur_y, cur_y_n;
    logic [7:0]          hi_byte, hi_byte_n;
    logic                pix_valid, pix_valid_n;
    logic [COORD_W-1:0]  pix_x, pix_x_n, pix_y, pix_y_n;
    logic [RGB565_W-1:0] pix_color, pix_color_n;

    // Decoder state, window registers, write pointer and pixel output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            param_idx <= 2'd0;
            x_start   <= '0;
            x_end     <= X_END_DEFAULT;
            y_start   <= '0;
            y_end     <= Y_END_DEFAULT;
            cur_x     <= '0;
            cur_y     <= '0;
            hi_byte   <= 8'd0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_color <= '0;
        end else begin
            state     <= state_n;
            param_idx <= param_idx_n;
            x_start   <= x_start_n;
            x_end     <= x_end_n;
            y_start   <= y_start_n;
            y_end     <= y_end_n;
            cur_x     <= cur_x_n;
            cur_y     <= cur_y_n;
            hi_byte   <= hi_byte_n;
            pix_valid <= pix_valid_n;
            pix_x     <= pix_x_n;
            pix_y     <= pix_y_n;
            pix_color <= pix_color_n;
        end
    end

    // Command/parameter decode per received byte and raster-order pointer advance after each pixel.
    always_comb begin
        state_n     = state;
        param_idx_n = param_idx;
        x_start_n   = x_start;
        x_end_n     = x_end;
        y_start_n   = y_start;
        y_end_n     = y_end;
        cur_x_n     = cur_x;
        cur_y_n     = cur_y;
        hi_byte_n   = hi_byte;
        pix_valid_n = 1'b0;
        pix_x_n     = pix_x;
        pix_y_n     = pix_y;
        pix_color_n = pix_color;

        if (rx_valid) begin
            if (!rx_dc) begin
                // A command always restarts decoding; a half-received pixel is simply abandoned.
                param_idx_n = 2'd0;
                case (rx_data)
                    CMD_CASET: state_n = ST_CASET_P;
                    CMD_PASET: state_n = ST_PASET_P;
                    CMD_RAMWR: begin
                        state_n = ST_RAMWR_HI;
                        cur_x_n = x_start;
                        cur_y_n = y_start;
                    end
                    default:   state_n = ST_IDLE;
                endcase
            end else begin
                case (state)
                    ST_CASET_P: begin
                        case (param_idx)
                            2'd0: x_start_n[15:8] = rx_data;
                            2'd1: x_start_n[7:0]  = rx_data;
                            2'd2: x_end_n[15:8]   = rx_data;
                            default: x_end_n[7:0] = rx_data;
                        endcase
                        param_idx_n = param_idx + 2'd1;
                        if (param_idx == 2'd3) state_n = ST_IDLE;
                    end
                    ST_PASET_P: begin
                        case (param_idx)
                            2'd0: y_start_n[15:8] = rx_data;
                            2'd1: y_start_n[7:0]  = rx_data;
                            2'd2: y_end_n[15:8]   = rx_data;
                            default: y_end_n[7:0] = rx_data;
                        endcase
                        param_idx_n = param_idx + 2'd1;
                        if (param_idx == 2'd3) state_n = ST_IDLE;
                    end
                    ST_RAMWR_HI: begin
                        hi_byte_n = rx_data;
                        state_n   = ST_RAMWR_LO;
                    end
                    ST_RAMWR_LO: begin
                        pix_valid_n = 1'b1;
                        pix_x_n     = cur_x[COORD_W-1:0];
                        pix_y_n     = cur_y[COORD_W-1:0];
                        pix_color_n = {hi_byte, rx_data};
                        state_n     = ST_RAMWR_HI;
                        // Wrap compares are exact 16-bit equality so start > end walks through 0xFFFF.
                        if (cur_x == x_end) begin
                            cur_x_n = x_start;
                            if (cur_y == y_end) cur_y_n = y_start;
                            else                cur_y_n = cur_y + 16'd1;
                        end else begin
                            cur_x_n = cur_x + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.byte_data    = rx_data;
    assign bus.byte_dc      = rx_dc;
    assign bus.byte_valid   = rx_valid;
    assign bus.ramwr_active = (state == ST_RAMWR_HI) || (state == ST_RAMWR_LO);
    assign bus.pixel_valid  = pix_valid;
    assign bus.pixel_x      = pix_x;
    assign bus.pixel_y      = pix_y;
    assign bus.pixel_color  = pix_color;

endmodule

// File: tb/tb_tft_spi_receiver.sv
// tb/tb_tft_spi_receiver.sv - self-checking bench for tft_spi_receiver (honours TFT_RX_SYNC_EN)
module tb_tft_spi_receiver;
    import tft_pkg::*;

`ifdef TFT_RX_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    tft_spi_receiver_if bus_if ();

    tft_spi_receiver dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_cmp    = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rise_cyc = 0;
    bit bv_prev  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Captured DUT traffic: {dc, data} and {x, y, color}
    logic [8:0]  got_bytes[$];
    logic [33:0] got_pix[$];
    logic [8:0]  exp_bytes[$];
    logic [33:0] exp_pix[$];

    always @(negedge clk) begin
        if (bus_if.byte_valid) begin
            got_bytes.push_back({bus_if.byte_dc, bus_if.byte_data});
            check("byte_latency", 64'(cyc - rise_cyc), 64'(LAT));
            check("byte_valid_width", 64'(bv_prev), 64'd0);
        end
        bv_prev = bus_if.byte_valid;
        if (bus_if.pixel_valid)
            got_pix.push_back({bus_if.pixel_x, bus_if.pixel_y, bus_if.pixel_color});
    end

    // Reference model: window registers plus a pixel count since RAMWR; coordinates come from div/mod.
    int m_mode, m_idx, m_hi_pend, m_hi, npix;
    int xs, xe, ys, ye;

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_hi_pend = 0; m_hi = 0; npix = 0;
        xs = 0; xe = 239; ys = 0; ye = 319;
    endtask

    function automatic int put_byte(input int word, input bit high, input logic [7:0] b);
        return high ? ((word & 32'h00FF) | (int'(b) << 8)) : ((word & 32'hFF00) | int'(b));
    endfunction

    task automatic model_byte(input bit dc, input logic [7:0] b);
        int w, h, x, y;
        exp_bytes.push_back({dc, b});
        if (!dc) begin
            m_hi_pend = 0;
            m_idx = 0;
            case (b)
                8'h2A: m_mode = 1;
                8'h2B: m_mode = 2;
                8'h2C: begin m_mode = 3; npix = 0; end
                default: m_mode = 0;
            endcase
        end else if (m_mode == 1 || m_mode == 2) begin
            if (m_mode == 1) begin
                if (m_idx < 2) xs = put_byte(xs, m_idx == 0, b);
                else           xe = put_byte(xe, m_idx == 2, b);
            end else begin
                if (m_idx < 2) ys = put_byte(ys, m_idx == 0, b);
                else           ye = put_byte(ye, m_idx == 2, b);
            end
            m_idx++;
            if (m_idx == 4) m_mode = 0;
        end else if (m_mode == 3) begin
            if (!m_hi_pend) begin
                m_hi = int'(b);
                m_hi_pend = 1;
            end else begin
                w = ((xe - xs) & 32'hFFFF) + 1;
                h = ((ye - ys) & 32'hFFFF) + 1;
                x = (xs + npix % w) & 32'hFFFF;
                y = (ys + (npix / w) % h) & 32'hFFFF;
                exp_pix.push_back({x[8:0], y[8:0], m_hi[7:0], b});
                npix++;
                m_hi_pend = 0;
            end
        end
    endtask

    // Drives the first nbits of b, MSB first, sclk = clk/4; called on a falling clk edge.
    task automatic send_bits(input bit dc, input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            bus_if.spi_sclk = 1'b0;
            bus_if.spi_mosi = b[i];
            bus_if.spi_dc   = dc;
            repeat (2) @(negedge clk);
            bus_if.spi_sclk = 1'b1;
            rise_cyc = cyc;
            repeat (2) @(negedge clk);
        end
        bus_if.spi_sclk = 1'b0;
    endtask

    task automatic send_byte(input bit dc, input logic [7:0] b);
        model_byte(dc, b);
        send_bits(dc, b, 8);
    endtask

    task automatic set_window(input logic [7:0] cmd, input logic [15:0] s, input logic [15:0] e);
        send_byte(1'b0, cmd);
        send_byte(1'b1, s[15:8]);
        send_byte(1'b1, s[7:0]);
        send_byte(1'b1, e[15:8]);
        send_byte(1'b1, e[7:0]);
    endtask

    task automatic send_pixels(input int n);
        logic [7:0] c;
        for (int i = 0; i < 2 * n; i++) begin
            c = 8'($urandom);
            send_byte(1'b1, c);
        end
    endtask

    task automatic check_queues(input string tag);
        repeat (8) @(negedge clk);
        check({tag, "_nbytes"}, 64'(got_bytes.size()), 64'(exp_bytes.size()));
        while (got_bytes.size() > 0 && exp_bytes.size() > 0)
            check({tag, "_byte"}, 64'(got_bytes.pop_front()), 64'(exp_bytes.pop_front()));
        check({tag, "_npix"}, 64'(got_pix.size()), 64'(exp_pix.size()));
        while (got_pix.size() > 0 && exp_pix.size() > 0)
            check({tag, "_pixel"}, 64'(got_pix.pop_front()), 64'(exp_pix.pop_front()));
        got_bytes.delete(); exp_bytes.delete();
        got_pix.delete();   exp_pix.delete();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s, e;
        bus_if.spi_sclk = 1'b0;
        bus_if.spi_mosi = 1'b0;
        bus_if.spi_dc   = 1'b0;
        bus_if.spi_cs   = 1'b1;
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_byte_valid", 64'(bus_if.byte_valid), 64'd0);
        check("rst_byte_data", 64'(bus_if.byte_data), 64'd0);
        check("rst_byte_dc", 64'(bus_if.byte_dc), 64'd0);
        check("rst_ramwr_active", 64'(bus_if.ramwr_active), 64'd0);
        check("rst_pixel_valid", 64'(bus_if.pixel_valid), 64'd0);
        check("rst_pixel_xy", 64'({bus_if.pixel_x, bus_if.pixel_y}), 64'd0);
        check("rst_pixel_color", 64'(bus_if.pixel_color), 64'd0);

        rst = 1'b1;
        bus_if.spi_cs = 1'b0;
        repeat (4) @(negedge clk);

        // Single pixel right after reset
        send_byte(1'b0, 8'h2C);
        repeat (LAT + 2) @(negedge clk);
        check("t1_ramwr_active", 64'(bus_if.ramwr_active), 64'd1);
        send_byte(1'b1, 8'hF8);
        send_byte(1'b1, 8'h00);
        check_queues("t1");

        // Small window raster walk with wrap back to the start
        set_window(8'h2A, 16'd5, 16'd6);
        set_window(8'h2B, 16'd10, 16'd11);
        send_byte(1'b0, 8'h2C);
        send_pixels(5);
        check_queues("t2");

        // Partial byte discarded by cs high
        send_bits(1'b0, 8'hA5, 5);
        bus_if.spi_cs = 1'b1;
        repeat (6) @(negedge clk);
        bus_if.spi_cs = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(1'b0, 8'h2C);
        check_queues("t3");

        // High byte dropped by a command; ramwr_active falls
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'hAB);
        repeat (LAT + 2) @(negedge clk);
        check("t4_ramwr_in", 64'(bus_if.ramwr_active), 64'd1);
        send_byte(1'b0, 8'h00);
        repeat (LAT + 2) @(negedge clk);
        check("t4_ramwr_out", 64'(bus_if.ramwr_active), 64'd0);
        check_queues("t4");

        // Randomized windows, ignored idle data, random colours
        for (int r = 0; r < 3; r++) begin
            s = 16'($urandom_range(0, 300));
            e = s + 16'($urandom_range(0, 3));
            set_window(8'h2A, s, e);
            send_byte(1'b1, 8'($urandom));
            s = 16'($urandom_range(0, 400));
            e = s + 16'($urandom_range(0, 2));
            set_window(8'h2B, s, e);
            send_byte(1'b0, 8'h2C);
            send_pixels(int'($urandom_range(1, 10)));
            check_queues("rnd");
        end

        // start > end: pointer runs through 0xFFFF to the end address
        set_window(8'h2A, 16'hFFFE, 16'h0001);
        set_window(8'h2B, 16'd7, 16'd7);
        send_byte(1'b0, 8'h2C);
        send_pixels(6);
        check_queues("wrap16");

        // Reset mid-byte restores defaults (x_end=239 seen via row wrap)
        set_window(8'h2A, 16'd0, 16'd3);
        check_queues("pre_rst");
        send_bits(1'b0, 8'hFF, 3);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        check("t6_rst_byte_valid", 64'(bus_if.byte_valid), 64'd0);
        check("t6_rst_pixel_valid", 64'(bus_if.pixel_valid), 64'd0);
        check("t6_rst_ramwr", 64'(bus_if.ramwr_active), 64'd0);
        repeat (4) @(negedge clk);
        send_byte(1'b0, 8'h2A);
        send_byte(1'b0, 8'h2C);
        send_pixels(241);
        check_queues("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
